// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, the
// multiply/divide sequencer states and a small two's-complement helper.
package ex_pkg;

    // ALU operation codes carried in the ID/EX register; 0 is what a flush delivers.
    localparam logic [6:0] OpNop  = 7'h00;
    localparam logic [6:0] OpAdd  = 7'h01;
    localparam logic [6:0] OpSub  = 7'h02;
    localparam logic [6:0] OpAnd  = 7'h03;
    localparam logic [6:0] OpOr   = 7'h04;
    localparam logic [6:0] OpXor  = 7'h05;
    localparam logic [6:0] OpSlt  = 7'h06;
    localparam logic [6:0] OpSll  = 7'h07;
    localparam logic [6:0] OpSrl  = 7'h08;
    localparam logic [6:0] OpSra  = 7'h09;
    localparam logic [6:0] OpLui  = 7'h0A;
    localparam logic [6:0] OpMult = 7'h10;
    localparam logic [6:0] OpDiv  = 7'h11;
    localparam logic [6:0] OpMfhi = 7'h12;
    localparam logic [6:0] OpMflo = 7'h13;

    // Iterative multiply/divide sequencer states.
    typedef enum logic [1:0] {
        MdIdle,
        MdBusy,
        MdDone
    } md_state_t;

    // Unsigned magnitude of a signed 32-bit value (-2^31 maps to 2^31).
    function automatic logic [31:0] magnitude(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed 32x32 multiplier / 32/32 divider, one bit per cycle.
// Works on operand magnitudes and fixes the signs when writing HI/LO.
// Only instantiated when EX_MULDIV_EN is defined.
module muldiv_unit
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,      // 0 = MULT, 1 = DIV
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    md_state_t   state_q;
    logic [4:0]  count_q;
    logic        is_div_q;
    logic        neg_res_q;   // sign of product / quotient
    logic        neg_rem_q;   // remainder takes the dividend sign
    logic        div_zero_q;
    logic [31:0] dividend_q;
    logic [31:0] mag_b_q;
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] mul_prod;
    logic [63:0] mul_fin;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;

    // One shift-add (mult) or restoring shift-subtract (div) step, plus final sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : 33'd0);
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        div_ge    = (div_shift >= {1'b0, mag_b_q});
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[31:0] : div_shift[31:0];
            step_lo = {acc_lo_q[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo_q[31:1]};
        end
        mul_prod = {step_hi, step_lo};
        mul_fin  = neg_res_q ? (~mul_prod + 64'd1) : mul_prod;
        if (!is_div_q) begin
            fin_hi = mul_fin[63:32];
            fin_lo = mul_fin[31:0];
        end else if (div_zero_q) begin
            fin_hi = dividend_q;
            fin_lo = 32'hFFFF_FFFF;
        end else begin
            fin_hi = neg_rem_q ? (~step_hi + 32'd1) : step_hi;
            fin_lo = neg_res_q ? (~step_lo + 32'd1) : step_lo;
        end
    end

    // Sequencer: latch operands on start, iterate 32 steps, write HI/LO, then one DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MdIdle;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
            mag_b_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                MdIdle: begin
                    if (start) begin
                        is_div_q   <= op;
                        neg_res_q  <= a[31] ^ b[31];
                        neg_rem_q  <= a[31];
                        div_zero_q <= (b == 32'd0);
                        dividend_q <= a;
                        mag_b_q    <= magnitude(b);
                        acc_hi_q   <= '0;
                        acc_lo_q   <= magnitude(a);
                        count_q    <= '0;
                        state_q    <= MdBusy;
                    end
                end
                MdBusy: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        hi_q    <= fin_hi;
                        lo_q    <= fin_lo;
                        state_q <= MdDone;
                    end
                end
                // The op leaves EX during DONE, so never restart from here.
                MdDone:  state_q <= MdIdle;
                default: state_q <= MdIdle;
            endcase
        end
    end

    // Busy rises in the issuing cycle itself so the pipeline holds immediately.
    always_comb begin
        busy = !reset && ((state_q == MdIdle && start) || state_q == MdBusy);
        done = (state_q == MdDone);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from MEM/WB, destination select, ALU.
// Define EX_MULDIV_EN to add the iterative MULT/DIV unit and HI/LO registers;
// without it codes 10-13 produce 0 and the stage never stalls.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  alu_op_e,
    input  logic [31:0] read_data_1_e,
    input  logic [31:0] read_data_2_e,
    input  logic [31:0] imm_e,
    input  logic        source_1_sel_e,
    input  logic        reg_dst_e,
    input  logic [4:0]  register_s_e,
    input  logic [4:0]  register_t_e,
    input  logic [4:0]  register_d_e,
    input  logic [31:0] alu_result_m,
    input  logic        reg_write_m,
    input  logic [4:0]  write_reg_m,
    input  logic [31:0] result_w,
    input  logic        reg_write_w,
    input  logic [4:0]  write_reg_w,
    output logic [31:0] alu_result_e,
    output logic [31:0] write_data_e,
    output logic [4:0]  write_reg_e,
    output logic        stall_e,
    output logic        ex_valid_e
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;

`ifdef EX_MULDIV_EN
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        unused_md_done;

    muldiv_unit u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (alu_op_e == OpMult || alu_op_e == OpDiv),
        .op    (alu_op_e == OpDiv),
        .a     (src_a),
        .b     (src_b),
        .busy  (md_busy),
        .hi    (md_hi),
        .lo    (md_lo),
        .done  (unused_md_done)
    );

    assign stall_e = md_busy;
`else
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign stall_e = 1'b0;
`endif

    assign ex_valid_e = !stall_e;

    // Forwarding: MEM beats WB; register 0 is never forwarded.
    always_comb begin
        if (reg_write_m && write_reg_m == register_s_e && register_s_e != 5'd0) begin
            src_a = alu_result_m;
        end else if (reg_write_w && write_reg_w == register_s_e && register_s_e != 5'd0) begin
            src_a = result_w;
        end else begin
            src_a = read_data_1_e;
        end
        if (reg_write_m && write_reg_m == register_t_e && register_t_e != 5'd0) begin
            fwd_b = alu_result_m;
        end else if (reg_write_w && write_reg_w == register_t_e && register_t_e != 5'd0) begin
            fwd_b = result_w;
        end else begin
            fwd_b = read_data_2_e;
        end
        src_b        = source_1_sel_e ? imm_e : fwd_b;
        write_data_e = fwd_b;
        write_reg_e  = reg_dst_e ? register_d_e : register_t_e;
    end

    // ALU result; MULT/DIV themselves report 0 (results appear via MFHI/MFLO).
    always_comb begin
        alu_result_e = 32'd0;
        case (alu_op_e)
            OpAdd:   alu_result_e = src_a + src_b;
            OpSub:   alu_result_e = src_a - src_b;
            OpAnd:   alu_result_e = src_a & src_b;
            OpOr:    alu_result_e = src_a | src_b;
            OpXor:   alu_result_e = src_a ^ src_b;
            OpSlt:   alu_result_e = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            OpSll:   alu_result_e = src_b << src_a[4:0];
            OpSrl:   alu_result_e = src_b >> src_a[4:0];
            OpSra:   alu_result_e = $unsigned($signed(src_b) >>> src_a[4:0]);
            OpLui:   alu_result_e = {src_b[15:0], 16'h0000};
`ifdef EX_MULDIV_EN
            OpMfhi:  alu_result_e = md_hi;
            OpMflo:  alu_result_e = md_lo;
`endif
            default: alu_result_e = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ALU and
// forwarding traffic against a behavioural model. MULT/DIV checks adapt to
// whether EX_MULDIV_EN is defined.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  alu_op_e;
    logic [31:0] read_data_1_e, read_data_2_e, imm_e;
    logic        source_1_sel_e, reg_dst_e;
    logic [4:0]  register_s_e, register_t_e, register_d_e;
    logic [31:0] alu_result_m, result_w;
    logic        reg_write_m, reg_write_w;
    logic [4:0]  write_reg_m, write_reg_w;
    logic [31:0] alu_result_e, write_data_e;
    logic [4:0]  write_reg_e;
    logic        stall_e, ex_valid_e;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .alu_op_e(alu_op_e),
        .read_data_1_e(read_data_1_e), .read_data_2_e(read_data_2_e), .imm_e(imm_e),
        .source_1_sel_e(source_1_sel_e), .reg_dst_e(reg_dst_e),
        .register_s_e(register_s_e), .register_t_e(register_t_e), .register_d_e(register_d_e),
        .alu_result_m(alu_result_m), .reg_write_m(reg_write_m), .write_reg_m(write_reg_m),
        .result_w(result_w), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
        .stall_e(stall_e), .ex_valid_e(ex_valid_e)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_op_e = OpNop; read_data_1_e = '0; read_data_2_e = '0; imm_e = '0;
        source_1_sel_e = 0; reg_dst_e = 0;
        register_s_e = '0; register_t_e = '0; register_d_e = '0;
        alu_result_m = '0; reg_write_m = 0; write_reg_m = '0;
        result_w = '0; reg_write_w = 0; write_reg_w = '0;
    endtask

    // Value a register read would see after forwarding.
    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rd);
        if (r == 0) return rd;
        if (reg_write_m && write_reg_m == r) return alu_result_m;
        if (reg_write_w && write_reg_w == r) return result_w;
        return rd;
    endfunction

    function automatic logic [31:0] model_alu(input logic [6:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        longint sb;
        sh = int'(a % 32);
        sb = longint'($signed(b));
        case (op)
            7'h01: return 32'(longint'(a) + longint'(b));
            7'h02: return 32'(longint'(a) - longint'(b));
            7'h03: return a & b;
            7'h04: return a | b;
            7'h05: return a ^ b;
            7'h06: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            7'h07: return 32'(longint'(b) * (longint'(1) << sh));
            7'h08: return 32'(longint'(b) / (longint'(1) << sh));
            7'h09: return 32'(sb >>> sh);
            7'h0A: return 32'(longint'(b) * 65536);
`ifdef EX_MULDIV_EN
            7'h12: return model_hi;
            7'h13: return model_lo;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_muldiv(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endtask

    // Issue MULT/DIV, scramble operands while busy, then check latency and HI/LO via MFLO/MFHI.
    task automatic run_muldiv(input string tag, input logic is_div, input logic [31:0] a,
                              input logic [31:0] b);
        int cycles;
        logic [31:0] eh, el;
        clear_inputs();
        alu_op_e = is_div ? OpDiv : OpMult;
        read_data_1_e = a;
        read_data_2_e = b;
        #1;
        cycles = 0;
        while (stall_e === 1'b1 && cycles < 100) begin
            cycles++;
            @(posedge clk);
            #1;
            read_data_1_e = $urandom;
            read_data_2_e = $urandom;
            #1;
        end
        model_muldiv(is_div, a, b, eh, el);
        model_hi = eh;
        model_lo = el;
        check({tag, "_stall_cycles"}, 32'(cycles), 32'd33);
        check({tag, "_done_result"}, alu_result_e, 32'd0);
        check({tag, "_done_valid"}, {31'd0, ex_valid_e}, 32'd1);
        alu_op_e = OpMflo;
        #1;
        check({tag, "_lo"}, alu_result_e, model_lo);
        tick();
        alu_op_e = OpMfhi;
        #1;
        check({tag, "_hi"}, alu_result_e, model_hi);
        check({tag, "_no_restart"}, {31'd0, stall_e}, 32'd0);
        tick();
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] a, bt;
        int cycles;

        // Reset: stall held low even with MULT present; combinational paths follow inputs.
        clear_inputs();
        reset = 1;
        alu_op_e = OpMult;
        #1;
        check("reset_stall", {31'd0, stall_e}, 32'd0);
        check("reset_valid", {31'd0, ex_valid_e}, 32'd1);
        alu_op_e = OpAdd; read_data_1_e = 2; read_data_2_e = 3;
        #1;
        check("reset_add_follows", alu_result_e, 32'd5);
        tick(); tick();
        reset = 0;
        clear_inputs();
        alu_op_e = OpMfhi; #1;
        check("reset_hi", alu_result_e, 32'd0);
        alu_op_e = OpMflo; #1;
        check("reset_lo", alu_result_e, 32'd0);
        alu_op_e = OpNop; read_data_1_e = 32'h55; read_data_2_e = 32'h66; #1;
        check("nop_zero", alu_result_e, 32'd0);

        // ADD without and with MEM forwarding.
        clear_inputs();
        alu_op_e = OpAdd; read_data_1_e = 5; read_data_2_e = 7;
        register_s_e = 3; register_t_e = 6;
        #1;
        check("add_plain", alu_result_e, 32'd12);
        reg_write_m = 1; write_reg_m = 3; alu_result_m = 100;
        #1;
        check("add_fwd_mem", alu_result_e, 32'd107);

        // MEM over WB on rt; register 0 never forwarded.
        clear_inputs();
        alu_op_e = OpOr; read_data_2_e = 32'hAA;
        register_t_e = 4;
        reg_write_m = 1; write_reg_m = 4; alu_result_m = 1;
        reg_write_w = 1; write_reg_w = 4; result_w = 2;
        #1;
        check("rt_mem_priority", write_data_e, 32'd1);
        reg_write_m = 0; #1;
        check("rt_wb_fwd", write_data_e, 32'd2);
        register_t_e = 0; write_reg_m = 0; write_reg_w = 0; reg_write_m = 1;
        #1;
        check("rt_reg0_nofwd", write_data_e, 32'hAA);

        // SLT / SRA / LUI corner cases.
        clear_inputs();
        alu_op_e = OpSlt; read_data_1_e = 32'hFFFF_FFFF; read_data_2_e = 1; #1;
        check("slt_neg", alu_result_e, 32'd1);
        alu_op_e = OpSra; read_data_1_e = 4; read_data_2_e = 32'h8000_0000; #1;
        check("sra_sign", alu_result_e, 32'hF800_0000);
        alu_op_e = OpLui; source_1_sel_e = 1; imm_e = 32'h0000_1234; #1;
        check("lui_imm", alu_result_e, 32'h1234_0000);
        check("imm_wdata_is_rt", write_data_e, 32'h8000_0000);

        // Destination select.
        register_t_e = 9; register_d_e = 17; reg_dst_e = 1; #1;
        check("wreg_rd", {27'd0, write_reg_e}, 32'd17);
        reg_dst_e = 0; #1;
        check("wreg_rt", {27'd0, write_reg_e}, 32'd9);

        // Randomized ALU + forwarding traffic.
        for (int i = 0; i < 200; i++) begin
            clear_inputs();
            op = 7'($urandom_range(0, 19));
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
`ifdef EX_MULDIV_EN
            if (op == OpMult || op == OpDiv) op = 7'h7F;
`endif
            alu_op_e = op;
            read_data_1_e = $urandom; read_data_2_e = $urandom;
            if ($urandom_range(0, 3) == 0) read_data_1_e = 32'($urandom_range(0, 40));
            imm_e = $urandom; source_1_sel_e = 1'($urandom);
            reg_dst_e = 1'($urandom);
            register_s_e = 5'($urandom_range(0, 3)); register_t_e = 5'($urandom_range(0, 3));
            register_d_e = 5'($urandom);
            reg_write_m = 1'($urandom); write_reg_m = 5'($urandom_range(0, 3));
            alu_result_m = $urandom;
            reg_write_w = 1'($urandom); write_reg_w = 5'($urandom_range(0, 3));
            result_w = $urandom;
            #1;
            a  = model_fwd(register_s_e, read_data_1_e);
            bt = model_fwd(register_t_e, read_data_2_e);
            check($sformatf("rand_alu_%0d_op%0h", i, op), alu_result_e,
                  model_alu(op, a, source_1_sel_e ? imm_e : bt));
            check($sformatf("rand_wdata_%0d", i), write_data_e, bt);
            check($sformatf("rand_wreg_%0d", i), {27'd0, write_reg_e},
                  {27'd0, reg_dst_e ? register_d_e : register_t_e});
            check($sformatf("rand_stall_%0d", i), {31'd0, stall_e}, 32'd0);
            tick();
        end

`ifdef EX_MULDIV_EN
        run_muldiv("mult_m3x7", 1'b0, 32'hFFFF_FFFD, 32'd7);
        run_muldiv("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_muldiv("div_9d0", 1'b1, 32'd9, 32'd0);
        run_muldiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            run_muldiv($sformatf("rand_md_%0d", i), 1'(i % 2), $urandom,
                       (i == 5) ? 32'($urandom_range(1, 9)) : $urandom);
        end

        // Reset 10 cycles into a MULT aborts it and clears HI/LO.
        clear_inputs();
        alu_op_e = OpMult; read_data_1_e = 32'd1234; read_data_2_e = 32'd5678;
        #1;
        cycles = 0;
        while (stall_e === 1'b1 && cycles < 10) begin
            cycles++;
            tick();
        end
        check("abort_reached_10", 32'(cycles), 32'd10);
        reset = 1; #1;
        check("abort_stall_in_reset", {31'd0, stall_e}, 32'd0);
        tick();
        check("abort_stall_after_edge", {31'd0, stall_e}, 32'd0);
        reset = 0; alu_op_e = OpNop; #1;
        check("abort_stall_idle", {31'd0, stall_e}, 32'd0);
        alu_op_e = OpMfhi; #1;
        check("abort_hi", alu_result_e, 32'd0);
        alu_op_e = OpMflo; #1;
        check("abort_lo", alu_result_e, 32'd0);
        model_hi = 0; model_lo = 0;
        tick();
        check("abort_still_idle", {31'd0, stall_e}, 32'd0);
        run_muldiv("mult_after_abort", 1'b0, 32'd1234, 32'd5678);
`else
        // Without the mul/div option these codes are inert.
        clear_inputs();
        read_data_1_e = 32'hFFFF_FFFD; read_data_2_e = 32'd7;
        for (int i = 0; i < 4; i++) begin
            alu_op_e = 7'(7'h10 + i);
            #1;
            check($sformatf("nomd_result_%0h", alu_op_e), alu_result_e, 32'd0);
            check($sformatf("nomd_stall_%0h", alu_op_e), {31'd0, stall_e}, 32'd0);
            tick();
            check($sformatf("nomd_stall_next_%0h", alu_op_e), {31'd0, stall_e}, 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
